// File: rtl/ula_controle.sv
// ula_controle: FIFO-buffered command sequencer for a 2-bit ULA with division-by-zero trap
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            request handshake; in_sel/in_a/in_b carry the request
//   ula_sel/ula_a/ula_b          registered operands driven to the ULA
//   ula_saida                    registered ULA result, trusted only in ESPERA
//   out_valid/out_ready          result handshake
//   out_saida/out_sel/out_erro   result, opcode tag, division-by-zero flag
//   nivel                        FIFO occupancy, 0..PROFUNDIDADE
module ula_controle #(
    parameter int PROFUNDIDADE = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_sel,
    input  logic [1:0]                      in_a,
    input  logic                            in_b,
    output logic [3:0]                      ula_sel,
    output logic [1:0]                      ula_a,
    output logic                            ula_b,
    input  logic [2:0]                      ula_saida,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2:0]                      out_saida,
    output logic [3:0]                      out_sel,
    output logic                            out_erro,
    output logic [$clog2(PROFUNDIDADE):0]   nivel
);
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0] CHEIO = (AW+1)'(PROFUNDIDADE);
    localparam logic [1:0] OCIOSO    = 2'd0;
    localparam logic [1:0] EMITE     = 2'd1;
    localparam logic [1:0] ESPERA    = 2'd2;
    localparam logic [1:0] RESULTADO = 2'd3;
    logic [6:0]    mem_q [PROFUNDIDADE];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   nivel_q, nivel_d;
    logic [6:0]    tag_q, tag_d, ula_q, ula_d;
    logic          out_valid_q, out_valid_d, out_erro_q, out_erro_d;
    logic [2:0]    out_saida_q, out_saida_d;
    logic [3:0]    out_sel_q, out_sel_d;
    logic          push, pop, trap;
    assign in_ready  = nivel_q != CHEIO;
    assign nivel     = nivel_q;
    assign ula_sel   = ula_q[6:3];
    assign ula_a     = ula_q[2:1];
    assign ula_b     = ula_q[0];
    assign out_valid = out_valid_q;
    assign out_saida = out_saida_q;
    assign out_sel   = out_sel_q;
    assign out_erro  = out_erro_q;
    always_comb begin
        push        = in_valid && in_ready;
        pop         = (state_q == OCIOSO) && (nivel_q != '0);
        // tag layout is {sel, a, b}: opcode 0011 is division, b is the divisor
        trap        = (tag_q[6:3] == 4'b0011) && !tag_q[0];
        wr_d        = push ? wr_q + AW'(1) : wr_q;
        rd_d        = pop ? rd_q + AW'(1) : rd_q;
        nivel_d     = nivel_q + (AW+1)'(push) - (AW+1)'(pop);
        ula_d       = pop ? mem_q[rd_q] : ula_q;
        tag_d       = pop ? mem_q[rd_q] : tag_q;
        state_d     = (state_q == OCIOSO) ? (pop ? EMITE : OCIOSO) :
                      (state_q == EMITE)  ? ESPERA :
                      (state_q == ESPERA) ? RESULTADO :
                      (out_ready ? OCIOSO : RESULTADO);
        out_valid_d = (state_q == ESPERA) ? 1'b1 :
                      ((state_q == RESULTADO) && out_ready) ? 1'b0 : out_valid_q;
        out_saida_d = (state_q == ESPERA) ? (trap ? 3'b111 : ula_saida) : out_saida_q;
        out_sel_d   = (state_q == ESPERA) ? tag_q[6:3] : out_sel_q;
        out_erro_d  = (state_q == ESPERA) ? trap : out_erro_q;
    end
    // storage carries no reset; occupancy and pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_sel, in_a, in_b};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCIOSO;
            wr_q        <= '0;
            rd_q        <= '0;
            nivel_q     <= '0;
            tag_q       <= '0;
            ula_q       <= '0;
            out_valid_q <= 1'b0;
            out_saida_q <= '0;
            out_sel_q   <= '0;
            out_erro_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            nivel_q     <= nivel_d;
            tag_q       <= tag_d;
            ula_q       <= ula_d;
            out_valid_q <= out_valid_d;
            out_saida_q <= out_saida_d;
            out_sel_q   <= out_sel_d;
            out_erro_q  <= out_erro_d;
        end
    end
endmodule

// File: tb/tb_ula_controle.sv
// tb_ula_controle: self-checking bench for ula_controle with a registered ULA model and result scoreboard
module tb_ula_controle;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [3:0] in_sel = '0;
    logic [1:0] in_a = '0;
    logic       in_b = 1'b0;
    logic [3:0] ula_sel;
    logic [1:0] ula_a;
    logic       ula_b;
    logic [2:0] ula_saida;
    logic       out_valid, out_ready = 1'b0;
    logic [2:0] out_saida;
    logic [3:0] out_sel;
    logic       out_erro;
    logic [2:0] nivel;
    int n_chk = 0, n_fail = 0, n_push = 0, n_res = 0, n_lost = 0;
    logic [7:0] exp_q[$];
    bit         stalled = 0;
    logic [8:0] held;
    typedef struct {
        logic [3:0] sel;
        logic [1:0] a;
        logic       b;
        logic [2:0] saida;
        logic       erro;
    } vec_t;
    vec_t tbl [12];
    logic [3:0] bp_sel [6];
    ula_controle #(.PROFUNDIDADE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
        .ula_sel(ula_sel), .ula_a(ula_a), .ula_b(ula_b), .ula_saida(ula_saida),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_saida(out_saida), .out_sel(out_sel), .out_erro(out_erro),
        .nivel(nivel)
    );
    always #5 clk = ~clk;
    // stand-in ULA: one-cycle registered, no reset, garbage on divide by zero
    function automatic logic [2:0] ula_f(input logic [3:0] s, input logic [1:0] a, input logic b);
        logic [2:0] x, y;
        x = {1'b0, a};
        y = {2'b00, b};
        case (s)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0010: return x * y;
            4'b0011: return b ? x : 3'b010;
            4'b1110: return x >> y;
            default: return x ^ s[2:0] ^ y;
        endcase
    endfunction
    always @(posedge clk) ula_saida <= ula_f(ula_sel, ula_a, ula_b);
    // expected {sel, saida, erro} for a request
    function automatic logic [7:0] model(input logic [3:0] s, input logic [1:0] a, input logic b);
        return (s == 4'b0011 && !b) ? {s, 3'b111, 1'b1} : {s, ula_f(s, a, b), 1'b0};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    // scoreboard sampled mid-cycle: handshakes seen here complete at the next rising edge
    task automatic monitor();
        logic [7:0] e;
        if (rst) begin
            n_lost += exp_q.size();
            exp_q.delete();
            stalled = 0;
            return;
        end
        if (stalled) check("stall_hold", {out_valid, out_sel, out_saida, out_erro}, held);
        stalled = out_valid && !out_ready;
        held = {out_valid, out_sel, out_saida, out_erro};
        if (out_valid && out_ready) begin
            n_res++;
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result", {out_sel, out_saida, out_erro}, e);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_sel, in_a, in_b));
            n_push++;
        end
    endtask
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] s, input logic [1:0] a, input logic b);
        in_valid = 1'b1;
        in_sel = s;
        in_a = a;
        in_b = b;
    endtask
    task automatic drain(input bit rnd);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            step();
            done = exp_q.size() == 0 && nivel == 0 && !out_valid;
        end
        check("drain", done, 1);
    endtask
    // single op through an idle block with out_ready high, checking each latency step
    task automatic run_op(input logic [3:0] s, input logic [1:0] a, input logic b,
                          input logic [2:0] saida, input logic erro);
        out_ready = 1'b1;
        drive(s, a, b);
        step();
        in_valid = 1'b0;
        check("nivel_after_push", nivel, 1);
        step();
        check("ula_inputs", {ula_sel, ula_a, ula_b}, {s, a, b});
        check("nivel_after_pop", nivel, 0);
        step();
        check("valid_early", out_valid, 0);
        check("ula_inputs_hold", {ula_sel, ula_a, ula_b}, {s, a, b});
        step();
        check("valid", out_valid, 1);
        check("saida", out_saida, saida);
        check("sel_tag", out_sel, s);
        check("erro", out_erro, erro);
        step();
        check("valid_clear", out_valid, 0);
    endtask
    task automatic push3();
        drive(4'b0101, 2'd1, 1'b1);
        step();
        drive(4'b0110, 2'd2, 1'b0);
        step();
        drive(4'b0111, 2'd3, 1'b1);
        step();
        in_valid = 1'b0;
    endtask
    initial begin
        int target;
        bit seen;
        tbl[0]  = '{4'b0000, 2'd3, 1'b1, 3'd4, 1'b0};
        tbl[1]  = '{4'b0011, 2'd2, 1'b0, 3'd7, 1'b1};
        tbl[2]  = '{4'b0011, 2'd3, 1'b1, 3'd3, 1'b0};
        tbl[3]  = '{4'b0001, 2'd1, 1'b1, 3'd0, 1'b0};
        tbl[4]  = '{4'b0001, 2'd0, 1'b1, 3'd7, 1'b0};
        tbl[5]  = '{4'b1110, 2'd2, 1'b1, 3'd1, 1'b0};
        tbl[6]  = '{4'b0010, 2'd3, 1'b1, 3'd3, 1'b0};
        tbl[7]  = '{4'b1111, 2'd2, 1'b1, 3'd4, 1'b0};
        tbl[8]  = '{4'b0011, 2'd0, 1'b0, 3'd7, 1'b1};
        tbl[9]  = '{4'b0100, 2'd1, 1'b0, 3'd5, 1'b0};
        tbl[10] = '{4'b0011, 2'd1, 1'b0, 3'd7, 1'b1};
        tbl[11] = '{4'b0000, 2'd2, 1'b0, 3'd2, 1'b0};
        bp_sel[0] = 4'b0000; bp_sel[1] = 4'b0001; bp_sel[2] = 4'b1000;
        bp_sel[3] = 4'b1001; bp_sel[4] = 4'b1111; bp_sel[5] = 4'b0101;
        // reset state
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_nivel", nivel, 0);
        check("rst_ula", {ula_sel, ula_a, ula_b}, 0);
        check("rst_out", {out_valid, out_saida, out_sel, out_erro}, 0);
        rst = 1'b0;
        step();
        // single-op vectors
        for (int i = 0; i < 12; i++) run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].saida, tbl[i].erro);
        // full FIFO with consumer stalled; the sixth request must be refused
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(bp_sel[i], 2'(i), 1'(i));
            step();
        end
        check("full_nivel", nivel, 4);
        check("full_in_ready", in_ready, 0);
        check("full_first_popped", ula_sel, 4'b0000);
        in_valid = 1'b0;
        repeat (3) step();
        check("full_nivel_hold", nivel, 4);
        check("full_out_valid", out_valid, 1);
        check("full_out_sel", out_sel, 4'b0000);
        drain(0);
        // simultaneous push and pop with two queued
        out_ready = 1'b0;
        push3();
        repeat (2) step();
        check("pp_nivel_before", nivel, 2);
        out_ready = 1'b1;
        step();
        check("pp_idle", out_valid, 0);
        drive(4'b1010, 2'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check("pp_nivel_same", nivel, 2);
        check("pp_popped_order", {ula_sel, ula_a, ula_b}, {4'b0110, 2'd2, 1'b0});
        drain(0);
        // reset while waiting on the ULA with two entries queued
        out_ready = 1'b1;
        push3();
        check("mid_nivel", nivel, 2);
        rst = 1'b1;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_nivel_clr", nivel, 0);
        check("mid_ula_sel", ula_sel, 4'b0000);
        check("mid_out_sel", out_sel, 4'b0000);
        check("mid_in_ready", in_ready, 1);
        repeat (2) step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= out_valid;
        end
        check("no_stale_result", seen, 0);
        run_op(4'b1110, 2'd2, 1'b1, 3'd1, 1'b0);
        // random stream with random backpressure, wrapping the pointers several times
        target = n_push + 24;
        for (int i = 0; i < 2000 && n_push < target; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 4'b0011 : 4'($urandom), 2'($urandom), 1'($urandom));
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("random_pushes", n_push, target);
        drain(1);
        check("results_total", n_res, n_push - n_lost);
        check("queue_empty_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_controle.md
# ula_controle

Command sequencer that sits directly upstream of the 2-bit ULA. It buffers operation requests (Sel, A, B) in a small FIFO and drives them onto the ULA inputs one at a time. It waits out the ULA's one-cycle registered latency, captures Saida, and returns each result with its opcode tag over a valid/ready handshake. It also traps division by zero, so undefined results never reach the consumer.

## Interface
- PROFUNDIDADE, 4: FIFO depth in entries; power of 2, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept; equals !cheio.
- in_sel  in  4  opcode (ULA encoding 0000..1111).
- in_a  in  2  operand A.
- in_b  in  1  operand B.
- ula_sel  out  4  registered, to ULA Sel.
- ula_a  out  2  registered, to ULA A.
- ula_b  out  1  registered, to ULA B.
- ula_saida  in  3  from ULA Saida.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_saida  out  3  result value.
- out_sel  out  4  opcode that produced out_saida.
- out_erro  out  1  1 = division by zero trapped.
- nivel  out  $clog2(PROFUNDIDADE)+1  FIFO occupancy.

## Operation
- FIFO: entry is {sel, a, b} (7 bits); write/read pointers wrap modulo PROFUNDIDADE; occupancy counter 0..PROFUNDIDADE.
- Push when in_valid && in_ready. No bypass: data pushed at edge N is poppable no earlier than edge N+1.
- Pop only in state OCIOSO with nivel != 0.
- Push and pop in the same cycle: both happen, nivel unchanged.
- When full, in_ready = 0 even if a pop occurs that cycle.
- FSM states:
  - OCIOSO: if FIFO is non-empty, pop the entry, load ula_sel/ula_a/ula_b and a private tag register, then go to EMITE. Otherwise stay.
  - EMITE: ULA inputs are stable; the ULA samples them at the closing edge. Go unconditionally to ESPERA.
  - ESPERA: ula_saida is valid. At the closing edge, load out_saida ← ula_saida, out_sel ← tag, out_erro ← 0, set out_valid, and go to RESULTADO.
    - Division-by-zero trap: if tag sel == 4'b0011 and tag b == 0, load out_saida ← 3'b111 and out_erro ← 1 instead.
  - RESULTADO: hold out_* stable while out_valid=1 && out_ready=0. On out_ready=1, clear out_valid and return to OCIOSO.
- ula_* outputs hold their last value outside EMITE/ESPERA; they never change while in EMITE or ESPERA.
- ula_saida is ignored in every state except ESPERA.
- The ULA has no reset, so its output is untrusted until the first ESPERA.
- Width rules: out_saida is passed through at 3 bits with no extension; nivel counts up to PROFUNDIDADE inclusive.

## Timing
- Reset (async assert, released synchronously to clk by the system) sets:
  - state = OCIOSO, pointers = 0, nivel = 0
  - in_ready = 1
  - ula_sel = 4'b0000, ula_a = 0, ula_b = 0
  - out_valid = 0, out_saida = 0, out_sel = 0, out_erro = 0
- Reset mid-operation discards the FIFO contents and any in-flight op. No result is emitted for them.
- Latency:
  - Pop edge E0: state → EMITE.
  - E1: ULA captures.
  - E2: result registered; out_valid = 1 from E2 until handshake.
  - Minimum 3 cycles from push-visible to out_valid; entry pushed at edge P gives out_valid after P+3 when idle.
- Throughput: with out_ready held high, one result per 4 cycles (OCIOSO, EMITE, ESPERA, RESULTADO).
- out_* and ula_* are registered outputs with no combinational paths from inputs. in_ready depends only on registered nivel.

## Test plan
- Soma: push sel=0000, a=3, b=1 into an idle block, out_ready=1 → ula_sel=0000/ula_a=3/ula_b=1 during EMITE; out_valid high 3 cycles after push, out_saida=3'b100, out_sel=0000, out_erro=0.
- Div-by-zero: push sel=0011, a=2, b=0 → out_saida=3'b111, out_erro=1, same latency. Follow with sel=0011, a=3, b=1 → out_saida=3, out_erro=0.
- Full/backpressure:
  - Hold out_ready=0 and push 5 ops (sel 0000,0001,1000,1001,1111): 1st popped, nivel reaches 4, in_ready=0, 6th request not accepted.
  - Release out_ready: results emerge in push order with correct out_sel tags; out_* stay stable while stalled.
- Simultaneous push/pop: with nivel=2 in OCIOSO, push in the pop cycle → nivel stays 2, FIFO order preserved.
- Reset mid-op: assert rst during ESPERA with 2 entries queued → immediately out_valid=0, nivel=0, ula_sel=0. After release, no stale result appears; a new push of sel=1110, a=2, b=1 yields out_saida=1.
- Wrap-around: stream 10 ops through PROFUNDIDADE=4 with random out_ready → all 10 results correct and in order, no loss or duplication.
